// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC command scheduler.
package dac_pkg;

  typedef enum logic [2:0] {
    ST_INIT_ISSUE,
    ST_INIT_WAIT,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } dac_sched_state_t;

  localparam logic [7:0]  DAC_CMD_WRITE_UPDATE = 8'h03;
  localparam logic [31:0] DAC_INIT_WORD        = 32'h08000001;
  localparam int unsigned DAC_TIMEOUT_DEFAULT  = 8192;

  // Write-and-update command: opcode, channel address, 12-bit code, pad byte.
  function automatic logic [31:0] dac_cmd_word(input logic [3:0] ch, input logic [11:0] code);
    return {DAC_CMD_WRITE_UPDATE, ch, code, 8'h00};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector; the search starts at ptr+1 and wraps.
module rr_arbiter #(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0] req,
  input  logic [3:0]     ptr,
  output logic [3:0]     grant,
  output logic           valid
);

  int best;
  int off;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    best  = NCH;
    off   = 0;
    for (int j = 0; j < NCH; j++) begin
      // distance of channel j after ptr, 0 meaning ptr+1
      off = (j + 2 * NCH - 1 - int'(ptr)) % NCH;
      if (req[j] && off < best) begin
        best  = off;
        grant = 4'(j);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dac_cmd_scheduler.sv
// Serialises one init command then round-robin channel writes onto a single SPI transmitter.
module dac_cmd_scheduler
  import dac_pkg::*;
#(
  parameter int          NCH       = 4,
  parameter logic [31:0] INIT_WORD = DAC_INIT_WORD,
  parameter int unsigned TIMEOUT   = DAC_TIMEOUT_DEFAULT
) (
  input  logic              clk100mhz,
  input  logic              rstn,
  input  logic [NCH-1:0]    req,
  input  logic [12*NCH-1:0] ch_data,
  output logic [NCH-1:0]    ack,
  output logic              tx_start,
  output logic [31:0]       tx_word,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic              init_done,
  output logic              timeout_err
);

  dac_sched_state_t state, state_nxt;
  logic [3:0]  ptr, g, gnt;
  logic        gnt_vld;
  logic [11:0] sel_data;
  logic [31:0] wdog;
  logic        wd_hit, ld_init, ld_grant, start, done, tmo;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (gnt),
    .valid (gnt_vld)
  );

  assign wd_hit = (wdog == 32'(TIMEOUT - 1));

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NCH; i++)
      if (gnt == 4'(i)) sel_data = ch_data[12*i +: 12];
  end

  always_ff @(posedge clk100mhz or negedge rstn) begin
    if (!rstn) state <= ST_INIT_ISSUE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_init   = 1'b0;
    ld_grant  = 1'b0;
    start     = 1'b0;
    done      = 1'b0;
    tmo       = 1'b0;
    case (state)
      ST_INIT_ISSUE: if (!tx_busy) begin
        ld_init   = 1'b1;
        start     = 1'b1;
        state_nxt = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: if (tx_done) begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end else if (wd_hit) begin
        tmo       = 1'b1;
        state_nxt = ST_INIT_ISSUE;
      end
      ST_IDLE: if (gnt_vld) begin
        ld_grant  = 1'b1;
        state_nxt = ST_ISSUE;
      end
      ST_ISSUE: if (!tx_busy) begin
        start     = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: if (tx_done) begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end else if (wd_hit) begin
        tmo       = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_INIT_ISSUE;
    endcase
  end

  always_ff @(posedge clk100mhz or negedge rstn) begin
    if (!rstn) begin
      ptr         <= 4'(NCH - 1);
      g           <= '0;
      tx_word     <= '0;
      tx_start    <= 1'b0;
      ack         <= '0;
      init_done   <= 1'b0;
      timeout_err <= 1'b0;
      wdog        <= '0;
    end else begin
      tx_start <= start;
      for (int i = 0; i < NCH; i++)
        ack[i] <= done && (state == ST_WAIT) && (g == 4'(i));
      // watchdog restarts with every tx_start and only runs while waiting
      if (start) wdog <= '0;
      else if (state == ST_INIT_WAIT || state == ST_WAIT) wdog <= wdog + 32'd1;
      if (ld_init) tx_word <= INIT_WORD;
      if (ld_grant) begin
        g       <= gnt;
        tx_word <= dac_cmd_word(gnt, sel_data);
      end
      if (done && state == ST_INIT_WAIT) init_done <= 1'b1;
      if (tmo) timeout_err <= 1'b1;
      if ((done || tmo) && state == ST_WAIT) ptr <= g;
    end
  end

endmodule

// File: tb/tb_dac_cmd_scheduler.sv
// Scoreboard bench: stimulus queues expected words/acks, a monitor pops them as the DUT emits.
module tb_dac_cmd_scheduler;

  logic        clk100mhz = 1'b0;
  logic        rstn;
  logic [3:0]  req = '0;
  logic [47:0] ch_data = '0;
  logic [3:0]  ack;
  logic        tx_start;
  logic [31:0] tx_word;
  logic        tx_busy = 1'b0;
  logic        tx_done = 1'b0;
  logic        init_done;
  logic        timeout_err;

  int vectors = 0;
  int miscompares = 0;
  int start_cnt = 0;
  int ack_cnt = 0;
  int stop_at = -1;
  bit auto_drop = 1'b1;
  bit suppress_next = 1'b0;
  logic [31:0] exp_word[$];
  logic [3:0]  exp_ack[$];

  dac_cmd_scheduler #(.NCH(4), .INIT_WORD(32'h08000001), .TIMEOUT(64)) dut (
    .clk100mhz   (clk100mhz),
    .rstn        (rstn),
    .req         (req),
    .ch_data     (ch_data),
    .ack         (ack),
    .tx_start    (tx_start),
    .tx_word     (tx_word),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .init_done   (init_done),
    .timeout_err (timeout_err)
  );

  always #5 clk100mhz = ~clk100mhz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk100mhz);
    #1;
  endtask

  task automatic wait_init(input int budget);
    int i = 0;
    while (!init_done && i < budget) begin tick(); i++; end
    check("init_done", 32'(init_done), 32'd1);
  endtask

  task automatic wait_acks(input int target, input int budget);
    int i = 0;
    while (ack_cnt < target && i < budget) begin tick(); i++; end
    check("ack_count", 32'(ack_cnt), 32'(target));
  endtask

  // SPI transmitter model: tx_done 40 cycles after tx_start, optionally swallowed once
  initial begin
    int  cnt  = 0;
    bit  supp = 1'b0;
    forever begin
      @(posedge clk100mhz);
      #1;
      tx_done = 1'b0;
      if (!rstn) cnt = 0;
      else if (tx_start) begin
        cnt = 40;
        supp = suppress_next;
        suppress_next = 1'b0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && !supp) tx_done = 1'b1;
      end
    end
  end

  // monitor: compares every emitted word/ack against the scoreboard
  initial begin
    forever begin
      @(negedge clk100mhz);
      if (tx_start) begin
        start_cnt++;
        if (exp_word.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL tx_word: actual %h, required no transfer", tx_word);
        end else check("tx_word", tx_word, exp_word.pop_front());
      end
      if (|ack) begin
        ack_cnt++;
        if (exp_ack.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL ack: actual %b, required no ack", ack);
        end else check("ack", 32'(ack), 32'(exp_ack.pop_front()));
        if (auto_drop) req = req & ~ack;
        if (ack_cnt == stop_at) req = '0;
      end
      if (tx_start && |ack) begin
        vectors++; miscompares++;
        $display("FAIL start_ack_overlap: actual ack=%b with tx_start, required none", ack);
      end
      if ($countones(ack) > 1) begin
        vectors++; miscompares++;
        $display("FAIL ack_onehot: actual %b, required at most one bit", ack);
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL global_timeout: actual still running, required finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int a0, s0, t;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    ch_data = {12'hDEF, 12'h000, 12'h456, 12'h123};
    tick(); tick();
    check("rst_tx_start",    32'(tx_start),    32'd0);
    check("rst_tx_word",     tx_word,          32'd0);
    check("rst_ack",         32'(ack),         32'd0);
    check("rst_init_done",   32'(init_done),   32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);

    exp_word.push_back(32'h08000001);
    rstn = 1'b1;
    check("tx_start_at_release", 32'(tx_start), 32'd0);
    wait_init(200);

    // single request on channel 2, also measures grant-to-start latency
    ch_data[35:24] = 12'hABC;
    exp_word.push_back(32'h032ABC00);
    exp_ack.push_back(4'b0100);
    req = 4'b0100;
    t = 0;
    while (!tx_start && t < 20) begin tick(); t++; end
    check("req_to_start_latency", 32'(t), 32'd2);
    wait_acks(1, 200);

    // move ptr to 3, then all channels held: 0,1,2,3,0
    exp_word.push_back(32'h033DEF00);
    exp_ack.push_back(4'b1000);
    req = 4'b1000;
    wait_acks(2, 200);
    auto_drop = 1'b0;
    stop_at = ack_cnt + 5;
    exp_word.push_back(32'h03012300); exp_ack.push_back(4'b0001);
    exp_word.push_back(32'h03145600); exp_ack.push_back(4'b0010);
    exp_word.push_back(32'h032ABC00); exp_ack.push_back(4'b0100);
    exp_word.push_back(32'h033DEF00); exp_ack.push_back(4'b1000);
    exp_word.push_back(32'h03012300); exp_ack.push_back(4'b0001);
    req = 4'b1111;
    wait_acks(7, 600);
    auto_drop = 1'b1;
    stop_at = -1;

    // transmitter busy while issuing; req dropped and data changed after grant
    tx_busy = 1'b1;
    s0 = start_cnt;
    exp_word.push_back(32'h03145600);
    exp_ack.push_back(4'b0010);
    req = 4'b0010;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (i == 5) begin
        req = '0;
        ch_data[23:12] = 12'h999;
      end
    end
    check("busy_no_start", 32'(start_cnt), 32'(s0));
    check("busy_word_hold", tx_word, 32'h03145600);
    tx_busy = 1'b0;
    wait_acks(8, 200);

    // first transfer times out, next requester served, timed-out channel retried
    suppress_next = 1'b1;
    a0 = ack_cnt;
    exp_word.push_back(32'h032ABC00);
    exp_word.push_back(32'h033DEF00); exp_ack.push_back(4'b1000);
    exp_word.push_back(32'h032ABC00); exp_ack.push_back(4'b0100);
    req = 4'b1100;
    t = 0;
    while (!tx_start && t < 20) begin tick(); t++; end
    t = 0;
    while (!timeout_err && t < 200) begin tick(); t++; end
    check("timeout_cycles", 32'(t), 32'd64);
    check("timeout_no_ack", 32'(ack_cnt), 32'(a0));
    wait_acks(a0 + 2, 400);
    check("timeout_sticky", 32'(timeout_err), 32'd1);

    // reset in the middle of a channel transfer
    s0 = start_cnt;
    exp_word.push_back(32'h03012300);
    req = 4'b0001;
    t = 0;
    while (start_cnt == s0 && t < 20) begin tick(); t++; end
    check("pre_reset_start", 32'(start_cnt), 32'(s0 + 1));
    for (int i = 0; i < 10; i++) tick();
    a0 = ack_cnt;
    rstn = 1'b0;
    req = '0;
    exp_word.push_back(32'h08000001);
    for (int i = 0; i < 3; i++) tick();
    check("mid_rst_tx_word",     tx_word,          32'd0);
    check("mid_rst_init_done",   32'(init_done),   32'd0);
    check("mid_rst_timeout_err", 32'(timeout_err), 32'd0);
    rstn = 1'b1;
    wait_init(200);
    for (int i = 0; i < 50; i++) tick();
    check("reset_no_ack",   32'(ack_cnt),         32'(a0));
    check("words_pending",  32'(exp_word.size()), 32'd0);
    check("acks_pending",   32'(exp_ack.size()),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
